win_message_sequencer: RTL and testbench

// - Sequences the winner-banner ROM (2-bit player select, 13-bit address, 3-bit colour data).
// - On game_over, latches the winner and starts the banner on the next frame boundary.
// - Each pixel inside a 128x64 window: computes the ROM address, registers the ROM colour, flags it valid.
// - Holds the banner for HOLD_FRAMES frames, then pulses restart to the game FSM; sits between VGA timing and the RGB mux.

---
 rtl/pong_pkg.sv | 25 ++
 rtl/msg_window_addr.sv | 50 +++++
 rtl/win_message_sequencer.sv | 130 +++++++++++++
 tb/tb_win_message_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong display/game-control blocks.
//   - state_t     : winner-banner sequencer states
//   - PLAYER_*    : winner / ROM player-select encodings
//   - MSG_ADDR_W  : width of the winner-banner ROM address
//   - is_player() : true for a real winner code (P1 or P2)
package pong_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_SHOW = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [1:0] PLAYER_NONE = 2'd0;
   localparam logic [1:0] PLAYER_P1   = 2'd1;
   localparam logic [1:0] PLAYER_P2   = 2'd2;

   localparam int MSG_ADDR_W = 13;

   function automatic logic is_player(input logic [1:0] code);
      return (code == PLAYER_P1) || (code == PLAYER_P2);
   endfunction

endpackage

// File: rtl/msg_window_addr.sv
// Banner window decode.
// Tells whether the current pixel lies inside the banner rectangle and forms
// the row-major ROM address of that pixel relative to the window origin.
//   pixel_x, pixel_y : current pixel column / row
//   in_win           : pixel inside the window (state-independent)
//   addr             : {row offset, column offset}; 0 outside the window
module msg_window_addr
   import pong_pkg::*;
#(
   parameter int MSG_X0 = 256,
   parameter int MSG_Y0 = 208,
   parameter int MSG_W  = 128,
   parameter int MSG_H  = 64
) (
   input  logic [9:0]            pixel_x,
   input  logic [9:0]            pixel_y,
   output logic                  in_win,
   output logic [MSG_ADDR_W-1:0] addr
);

   localparam int XW = $clog2(MSG_W);
   localparam int YW = $clog2(MSG_H);

   // Bounds carry one extra bit so MSG_X0+MSG_W can reach 1024 without wrapping.
   localparam logic [10:0] X_LO = 11'(MSG_X0);
   localparam logic [10:0] X_HI = 11'(MSG_X0 + MSG_W);
   localparam logic [10:0] Y_LO = 11'(MSG_Y0);
   localparam logic [10:0] Y_HI = 11'(MSG_Y0 + MSG_H);
   localparam logic [9:0]  X_OFF = 10'(MSG_X0);
   localparam logic [9:0]  Y_OFF = 10'(MSG_Y0);

   logic [XW-1:0] col;
   logic [YW-1:0] row;

   // NOTE: every output of this always_comb is assigned before any branch,
   // so no path leaves a value held and no latch is inferred.
   always_comb begin
      in_win = ({1'b0, pixel_x} >= X_LO) && ({1'b0, pixel_x} < X_HI) &&
               ({1'b0, pixel_y} >= Y_LO) && ({1'b0, pixel_y} < Y_HI);
      // Offsets are taken at full 10-bit width and only then truncated; the
      // result is used solely when the range check above passed.
      col  = XW'(pixel_x - X_OFF);
      row  = YW'(pixel_y - Y_OFF);
      addr = '0;
      if (in_win) begin
         addr = {row, col};
      end
   end

endmodule

// File: rtl/win_message_sequencer.sv
// Winner-banner sequencer.
// After a game ends it latches the winner, waits for a frame boundary, then
// shows the winner banner from ROM for HOLD_FRAMES frames and pulses restart.
//   clk, rst_n   : pixel clock, asynchronous active-low reset
//   game_over    : one-cycle end-of-game pulse, winner sampled with it
//   winner       : 1 = P1, 2 = P2 (0/3 ignored)
//   frame_start  : one-cycle pulse at each frame start
//   pixel_x/y    : current VGA pixel
//   rom_player   : ROM bank select, 0 blanks the ROM
//   rom_address  : registered ROM address
//   rom_data     : ROM colour, combinational from rom_address
//   msg_rgb      : registered banner colour
//   msg_valid    : msg_rgb overrides the playfield this cycle
//   busy         : game_over accepted and restart not yet issued
//   restart      : one-cycle pulse when the banner ends
module win_message_sequencer
   import pong_pkg::*;
#(
   parameter int MSG_X0      = 256,
   parameter int MSG_Y0      = 208,
   parameter int MSG_W       = 128,
   parameter int MSG_H       = 64,
   parameter int HOLD_FRAMES = 180
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        game_over,
   input  logic [1:0]  winner,
   input  logic        frame_start,
   input  logic [9:0]  pixel_x,
   input  logic [9:0]  pixel_y,
   output logic [1:0]  rom_player,
   output logic [12:0] rom_address,
   input  logic [2:0]  rom_data,
   output logic [2:0]  msg_rgb,
   output logic        msg_valid,
   output logic        busy,
   output logic        restart
);

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES);

   state_t          state;
   logic [7:0]      frame_cnt;
   logic [7:0]      cnt_inc;
   logic [1:0]      win_q;
   logic            hit1;
   logic            pix_in_win;
   logic            in_win;
   logic [MSG_ADDR_W-1:0] win_addr;

   msg_window_addr #(
      .MSG_X0 (MSG_X0),
      .MSG_Y0 (MSG_Y0),
      .MSG_W  (MSG_W),
      .MSG_H  (MSG_H)
   ) u_window (
      .pixel_x (pixel_x),
      .pixel_y (pixel_y),
      .in_win  (pix_in_win),
      .addr    (win_addr)
   );

   assign in_win  = pix_in_win && (state == ST_SHOW);
   assign cnt_inc = frame_cnt + 8'd1;

   // NOTE: all state here is updated with <= so every register samples the
   // pre-edge values of the others, which is what makes the two pipeline
   // stages and the FSM line up cycle-for-cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         frame_cnt   <= 8'd0;
         win_q       <= PLAYER_NONE;
         busy        <= 1'b0;
         restart     <= 1'b0;
         hit1        <= 1'b0;
         rom_player  <= PLAYER_NONE;
         rom_address <= '0;
         msg_valid   <= 1'b0;
         msg_rgb     <= 3'd0;
      end else begin
         restart <= 1'b0;

         case (state)
            ST_IDLE: begin
               // A coincident frame_start is deliberately not consumed here:
               // ARM always waits for the following frame boundary.
               if (game_over && is_player(winner)) begin
                  win_q <= winner;
                  busy  <= 1'b1;
                  state <= ST_ARM;
               end
            end
            ST_ARM: begin
               if (frame_start) begin
                  frame_cnt <= 8'd0;
                  state     <= ST_SHOW;
               end
            end
            ST_SHOW: begin
               if (frame_start) begin
                  frame_cnt <= cnt_inc;
                  if (cnt_inc == HOLD_LAST) begin
                     restart <= 1'b1;
                     state   <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               busy      <= 1'b0;
               win_q     <= PLAYER_NONE;
               frame_cnt <= 8'd0;
               state     <= ST_IDLE;
            end
         endcase

         // Stage 1: address and bank select toward the ROM.
         hit1        <= in_win;
         rom_player  <= in_win ? win_q : PLAYER_NONE;
         rom_address <= in_win ? win_addr : '0;

         // Stage 2: capture ROM colour. A pixel already in stage 1 when SHOW
         // ends still completes, so msg_valid can trail DONE by one cycle.
         msg_valid <= hit1;
         msg_rgb   <= hit1 ? rom_data : 3'd0;
      end
   end

endmodule

// File: tb/tb_win_message_sequencer.sv
// Directed self-checking bench for win_message_sequencer (HOLD_FRAMES = 3).
module tb_win_message_sequencer;

   logic        clk;
   logic        rst_n;
   logic        game_over;
   logic [1:0]  winner;
   logic        frame_start;
   logic [9:0]  pixel_x;
   logic [9:0]  pixel_y;
   logic [1:0]  rom_player;
   logic [12:0] rom_address;
   logic [2:0]  rom_data;
   logic [2:0]  msg_rgb;
   logic        msg_valid;
   logic        busy;
   logic        restart;

   int n_cmp = 0;
   int n_err = 0;
   int n_restart = 0;

   win_message_sequencer #(
      .MSG_X0      (256),
      .MSG_Y0      (208),
      .MSG_W       (128),
      .MSG_H       (64),
      .HOLD_FRAMES (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .game_over   (game_over),
      .winner      (winner),
      .frame_start (frame_start),
      .pixel_x     (pixel_x),
      .pixel_y     (pixel_y),
      .rom_player  (rom_player),
      .rom_address (rom_address),
      .rom_data    (rom_data),
      .msg_rgb     (msg_rgb),
      .msg_valid   (msg_valid),
      .busy        (busy),
      .restart     (restart)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural banner ROM: player 0 reads as blank.
   function automatic logic [2:0] rom_fn(input logic [1:0] player, input logic [12:0] addr);
      if (player == 2'd0) return 3'd0;
      return addr[2:0] ^ {1'b0, player} ^ {addr[12], 2'b00};
   endfunction

   always_comb rom_data = rom_fn(rom_player, rom_address);

   always @(negedge clk) begin
      if (restart === 1'b1) n_restart++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_rom_player"},  32'(rom_player),  0);
      check({pfx, "_rom_address"}, 32'(rom_address), 0);
      check({pfx, "_msg_rgb"},     32'(msg_rgb),     0);
      check({pfx, "_msg_valid"},   32'(msg_valid),   0);
      check({pfx, "_busy"},        32'(busy),        0);
      check({pfx, "_restart"},     32'(restart),     0);
   endtask

   task automatic set_pix(input int x, input int y);
      pixel_x = 10'(x);
      pixel_y = 10'(y);
   endtask

   typedef struct {
      logic [9:0]  x;
      logic [9:0]  y;
      logic        hit;
      logic [12:0] addr;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int idle_bad;
      int base;

      // {x, y, inside window, expected address} -- addresses hand-computed
      // as (y-208)*128 + (x-256).
      vecs[0] = '{10'd256,  10'd208,  1'b1, 13'd0};
      vecs[1] = '{10'd383,  10'd271,  1'b1, 13'd8191};
      vecs[2] = '{10'd384,  10'd271,  1'b0, 13'd0};
      vecs[3] = '{10'd255,  10'd208,  1'b0, 13'd0};
      vecs[4] = '{10'd300,  10'd250,  1'b1, 13'd5420};
      vecs[5] = '{10'd256,  10'd207,  1'b0, 13'd0};
      vecs[6] = '{10'd383,  10'd272,  1'b0, 13'd0};
      vecs[7] = '{10'd320,  10'd240,  1'b1, 13'd4160};
      vecs[8] = '{10'd1023, 10'd1023, 1'b0, 13'd0};
      vecs[9] = '{10'd0,    10'd0,    1'b0, 13'd0};

      rst_n = 1'b0; game_over = 1'b0; winner = 2'd0; frame_start = 1'b0;
      set_pix(256, 208);
      repeat (3) tick();
      check_all_zero("reset");
      rst_n = 1'b1;

      // Idle: in-window pixels must never light the banner.
      idle_bad = 0;
      for (int i = 0; i < 1000; i++) begin
         set_pix(256 + (i % 128), 208 + ((i / 128) % 64));
         tick();
         if (rom_player !== 2'd0 || msg_valid !== 1'b0 || busy !== 1'b0) idle_bad++;
      end
      check("idle_bad_cycles", 32'(idle_bad), 0);

      // Winner 3 in IDLE is ignored.
      set_pix(256, 208);
      game_over = 1'b1; winner = 2'd3;
      tick();
      game_over = 1'b0; winner = 2'd0;
      check("w3_busy", 32'(busy), 0);
      tick(); tick();
      check("w3_rom_player", 32'(rom_player), 0);
      check("w3_msg_valid", 32'(msg_valid), 0);

      // game_over + frame_start together: ARM, frame_start not consumed.
      game_over = 1'b1; winner = 2'd2; frame_start = 1'b1;
      tick();
      game_over = 1'b0; winner = 2'd0; frame_start = 1'b0;
      check("arm_busy", 32'(busy), 1);
      repeat (5) tick();
      check("arm_rom_player", 32'(rom_player), 0);
      check("arm_msg_valid", 32'(msg_valid), 0);
      check("arm_restart", 32'(restart), 0);

      // Frame pulse 1: ARM -> SHOW.
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check("p1_edge_rom_player", 32'(rom_player), 0);
      tick();
      check("show_rom_player", 32'(rom_player), 2);
      check("show_rom_address", 32'(rom_address), 0);
      tick();
      check("show_msg_valid", 32'(msg_valid), 1);
      check("show_msg_rgb", 32'(msg_rgb), 32'(rom_fn(2'd2, 13'd0)));

      // Window boundary table, winner 2 showing.
      for (int i = 0; i < 10; i++) begin
         pixel_x = vecs[i].x;
         pixel_y = vecs[i].y;
         tick();
         check($sformatf("vec%0d_rom_player", i), 32'(rom_player), vecs[i].hit ? 2 : 0);
         check($sformatf("vec%0d_rom_address", i), 32'(rom_address), 32'(vecs[i].addr));
         tick();
         check($sformatf("vec%0d_msg_valid", i), 32'(msg_valid), 32'(vecs[i].hit));
         check($sformatf("vec%0d_msg_rgb", i), 32'(msg_rgb),
               vecs[i].hit ? 32'(rom_fn(2'd2, vecs[i].addr)) : 0);
      end

      // Second game_over while busy is ignored.
      base = n_restart;
      set_pix(256, 208);
      game_over = 1'b1; winner = 2'd1;
      tick();
      game_over = 1'b0; winner = 2'd0;
      tick();
      check("regame_rom_player", 32'(rom_player), 2);
      check("regame_busy", 32'(busy), 1);

      // Frame pulses 2 and 3 keep the banner up.
      for (int p = 2; p <= 3; p++) begin
         frame_start = 1'b1;
         tick();
         frame_start = 1'b0;
         check($sformatf("pulse%0d_restart", p), 32'(restart), 0);
         repeat (10) tick();
      end
      check("pre_end_busy", 32'(busy), 1);
      check("pre_end_rom_player", 32'(rom_player), 2);

      // Frame pulse 4 ends the banner.
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check("done_restart", 32'(restart), 1);
      check("done_busy", 32'(busy), 1);
      tick();
      check("post_restart", 32'(restart), 0);
      check("post_busy", 32'(busy), 0);
      check("post_tail_msg_valid", 32'(msg_valid), 1);
      check("post_rom_player", 32'(rom_player), 0);
      tick();
      check("post_msg_valid_drop", 32'(msg_valid), 0);
      for (int p = 0; p < 3; p++) begin
         frame_start = 1'b1;
         tick();
         frame_start = 1'b0;
         repeat (5) tick();
      end
      check("single_restart_count", 32'(n_restart - base), 1);
      check("idle_again_busy", 32'(busy), 0);
      check("idle_again_rom_player", 32'(rom_player), 0);

      // Reset asserted mid-SHOW.
      game_over = 1'b1; winner = 2'd1;
      tick();
      game_over = 1'b0; winner = 2'd0;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick(); tick();
      check("rs_pre_rom_player", 32'(rom_player), 1);
      check("rs_pre_msg_valid", 32'(msg_valid), 1);
      check("rs_pre_msg_rgb", 32'(msg_rgb), 32'(rom_fn(2'd1, 13'd0)));
      base = n_restart;
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      for (int p = 0; p < 4; p++) begin
         frame_start = 1'b1;
         tick();
         frame_start = 1'b0;
         tick();
      end
      rst_n = 1'b1;
      repeat (10) tick();
      check("rs_post_busy", 32'(busy), 0);
      check("rs_post_rom_player", 32'(rom_player), 0);
      check("rs_post_msg_valid", 32'(msg_valid), 0);
      check("rs_no_restart", 32'(n_restart - base), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
